// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - field constants and transmit FSM states for the UART echo buffer
package uart_pkg;

    localparam int RX_PAR_BIT = 8;
    localparam int RX_FRM_BIT = 9;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_WLOW  = 2'd1,
        T_WHIGH = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_echo_buf_if.sv
// rtl/uart_echo_buf_if.sv - receive, transmit and statistics signals of the echo buffer
interface uart_echo_buf_if #(
    parameter int DEPTH = 16,
    parameter int CT_W  = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             RX_DATA_EN;
    logic [9:0]       RX_DATA_T;
    logic             ECHO_EN;
    logic             CT_CLR;
    logic             TX_RDY_R;
    logic             TX_RDY_T;
    logic [7:0]       TX_DATA_R;
    logic [LVL_W-1:0] FIFO_LVL;
    logic [CT_W-1:0]  PAR_ERR_CT;
    logic [CT_W-1:0]  FRM_ERR_CT;
    logic [CT_W-1:0]  OVF_CT;

    modport master (
        output RX_DATA_EN, RX_DATA_T, ECHO_EN, CT_CLR, TX_RDY_R,
        input  TX_RDY_T, TX_DATA_R, FIFO_LVL, PAR_ERR_CT, FRM_ERR_CT, OVF_CT
    );

    modport slave (
        input  RX_DATA_EN, RX_DATA_T, ECHO_EN, CT_CLR, TX_RDY_R,
        output TX_RDY_T, TX_DATA_R, FIFO_LVL, PAR_ERR_CT, FRM_ERR_CT, OVF_CT
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with registered read data and occupancy level
module uart_sync_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            if (push_ok && !pop_ok) begin
                level <= level + LW'(1);
            end else if (pop_ok && !push_ok) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_echo_buf.sv
// rtl/uart_echo_buf.sv - filters received words, buffers clean bytes and echoes them to the transmitter
module uart_echo_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CT_W  = 8
) (
    input logic            CLK,
    input logic            RST_N,
    uart_echo_buf_if.slave bus
);

    tx_state_t       state;
    tx_state_t       state_nx;
    logic            launch;
    logic            tx_rdy_t;
    logic            full;
    logic            empty;
    logic            frm_hit;
    logic            par_hit;
    logic            push_req;
    logic            ovf_hit;
    logic [CT_W-1:0] par_ct;
    logic [CT_W-1:0] frm_ct;
    logic [CT_W-1:0] ovf_ct;

    // Frame error outranks parity error so each bad word is counted once.
    assign frm_hit  = bus.RX_DATA_EN && bus.RX_DATA_T[RX_FRM_BIT];
    assign par_hit  = bus.RX_DATA_EN && !bus.RX_DATA_T[RX_FRM_BIT] && bus.RX_DATA_T[RX_PAR_BIT];
    assign push_req = bus.RX_DATA_EN && !bus.RX_DATA_T[RX_FRM_BIT] && !bus.RX_DATA_T[RX_PAR_BIT];
    assign ovf_hit  = push_req && full && !launch;

    uart_sync_fifo #(
        .W     (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (push_req),
        .wr_data (bus.RX_DATA_T[7:0]),
        .pop     (launch),
        .rd_data (bus.TX_DATA_R),
        .full    (full),
        .empty   (empty),
        .level   (bus.FIFO_LVL)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            par_ct <= '0;
            frm_ct <= '0;
            ovf_ct <= '0;
        end else if (bus.CT_CLR) begin
            par_ct <= '0;
            frm_ct <= '0;
            ovf_ct <= '0;
        end else begin
            if (par_hit && par_ct != {CT_W{1'b1}}) par_ct <= par_ct + CT_W'(1);
            if (frm_hit && frm_ct != {CT_W{1'b1}}) frm_ct <= frm_ct + CT_W'(1);
            if (ovf_hit && ovf_ct != {CT_W{1'b1}}) ovf_ct <= ovf_ct + CT_W'(1);
        end
    end

    assign bus.PAR_ERR_CT = par_ct;
    assign bus.FRM_ERR_CT = frm_ct;
    assign bus.OVF_CT     = ovf_ct;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= T_IDLE;
            tx_rdy_t <= 1'b0;
        end else begin
            state    <= state_nx;
            tx_rdy_t <= launch;
        end
    end

    // The request pulse is played out while still in T_IDLE; leaving only
    // after it ends keeps the request confined to the idle state.
    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        case (state)
            T_IDLE: begin
                if (tx_rdy_t) begin
                    state_nx = T_WLOW;
                end else if (bus.ECHO_EN && !empty && bus.TX_RDY_R) begin
                    launch = 1'b1;
                end
            end
            T_WLOW: begin
                if (!bus.TX_RDY_R) state_nx = T_WHIGH;
            end
            T_WHIGH: begin
                if (bus.TX_RDY_R) state_nx = T_IDLE;
            end
            default: state_nx = T_IDLE;
        endcase
    end

    assign bus.TX_RDY_T = tx_rdy_t;

endmodule

// File: tb/tb_uart_echo_buf.sv
// tb/tb_uart_echo_buf.sv - directed self-checking bench for uart_echo_buf
module tb_uart_echo_buf;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pulse_ct;
    int   pc0;
    logic [7:0] tx_q [$];
    logic [7:0] exp_q [$];

    uart_echo_buf_if #(.DEPTH(16), .CT_W(8)) bus ();

    uart_echo_buf #(.DEPTH(16), .CT_W(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.TX_RDY_T === 1'b1) begin
            pulse_ct++;
            tx_q.push_back(bus.TX_DATA_R);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] w);
        bus.RX_DATA_EN = 1'b1;
        bus.RX_DATA_T  = w;
        step(1);
        bus.RX_DATA_EN = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic serve(input int n);
        for (int b = 0; b < n; b++) begin
            int w;
            w = 0;
            while (bus.TX_RDY_T !== 1'b1 && w < 40) begin
                step(1);
                w++;
            end
            chk("serve_pulse", {31'd0, bus.TX_RDY_T}, 32'd1);
            bus.TX_RDY_R = 1'b0;
            step(3);
            bus.TX_RDY_R = 1'b1;
        end
        step(3);
    endtask

    initial begin
        checks = 0; errors = 0; pulse_ct = 0;
        rst_n = 1'b0;
        bus.RX_DATA_EN = 1'b0; bus.RX_DATA_T = '0; bus.ECHO_EN = 1'b1;
        bus.CT_CLR = 1'b0; bus.TX_RDY_R = 1'b1;
        step(2);
        chk("rst_lvl", bus.FIFO_LVL, 0);
        chk("rst_rdy_t", bus.TX_RDY_T, 0);
        chk("rst_data", bus.TX_DATA_R, 0);
        chk("rst_par", bus.PAR_ERR_CT, 0);
        chk("rst_frm", bus.FRM_ERR_CT, 0);
        chk("rst_ovf", bus.OVF_CT, 0);
        rst_n = 1'b1;
        step(2);

        // Single clean byte: request one cycle after the level update.
        send(10'h041);
        chk("t1_lvl_after_push", bus.FIFO_LVL, 1);
        chk("t1_no_early_pulse", bus.TX_RDY_T, 0);
        step(1);
        chk("t1_pulse", bus.TX_RDY_T, 1);
        chk("t1_data", bus.TX_DATA_R, 8'h41);
        chk("t1_lvl_popped", bus.FIFO_LVL, 0);
        step(1);
        chk("t1_pulse_end", bus.TX_RDY_T, 0);
        bus.TX_RDY_R = 1'b0;
        step(100);
        bus.TX_RDY_R = 1'b1;
        step(5);
        chk("t1_single_pulse", pulse_ct, 1);
        chk("t1_lvl_final", bus.FIFO_LVL, 0);
        chk("t1_data_stable", bus.TX_DATA_R, 8'h41);

        // Errored words are dropped and classified.
        send(10'h155);
        send(10'h2AA);
        send(10'h355);
        step(3);
        chk("t2_par", bus.PAR_ERR_CT, 1);
        chk("t2_frm", bus.FRM_ERR_CT, 2);
        chk("t2_lvl", bus.FIFO_LVL, 0);
        chk("t2_no_pulse", pulse_ct, 1);

        // Fill past capacity with echo held off.
        bus.ECHO_EN = 1'b0;
        for (int i = 0; i < 18; i++) send(10'(i));
        step(2);
        chk("t3_lvl_full", bus.FIFO_LVL, 16);
        chk("t3_ovf", bus.OVF_CT, 2);
        chk("t3_no_pulse", pulse_ct, 1);

        // Push 0x7E into a full FIFO in the same cycle as the first pop.
        tx_q.delete();
        bus.ECHO_EN = 1'b1;
        send(10'h07E);
        chk("t4_lvl_held", bus.FIFO_LVL, 16);
        chk("t4_ovf_same", bus.OVF_CT, 2);
        chk("t4_pulse", bus.TX_RDY_T, 1);
        chk("t4_first_data", bus.TX_DATA_R, 8'h00);
        serve(17);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h7E);
        chk("t3_echo_count", tx_q.size(), 17);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("t3_echo_byte%0d", i), (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]);
        end
        chk("t3_lvl_drained", bus.FIFO_LVL, 0);
        chk("t3_ovf_final", bus.OVF_CT, 2);

        // Parity counter saturation, then clear beating an increment.
        for (int i = 0; i < 260; i++) send(10'h100);
        step(1);
        chk("t5_par_sat", bus.PAR_ERR_CT, 255);
        chk("t5_frm_kept", bus.FRM_ERR_CT, 2);
        bus.CT_CLR = 1'b1;
        send(10'h100);
        bus.CT_CLR = 1'b0;
        chk("t5_par_clr", bus.PAR_ERR_CT, 0);
        chk("t5_frm_clr", bus.FRM_ERR_CT, 0);
        chk("t5_ovf_clr", bus.OVF_CT, 0);
        chk("t5_lvl", bus.FIFO_LVL, 0);

        // Reset in T_WHIGH with five bytes still buffered.
        bus.ECHO_EN = 1'b0;
        for (int i = 0; i < 6; i++) send(10'h0A0 + 10'(i));
        chk("t6_lvl6", bus.FIFO_LVL, 6);
        bus.ECHO_EN = 1'b1;
        step(1);
        chk("t6_pulse", bus.TX_RDY_T, 1);
        chk("t6_data", bus.TX_DATA_R, 8'hA0);
        bus.ECHO_EN = 1'b0;
        bus.TX_RDY_R = 1'b0;
        step(2);
        chk("t6_lvl5", bus.FIFO_LVL, 5);
        send(10'h3FF);
        chk("t6_frm_one", bus.FRM_ERR_CT, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_lvl", bus.FIFO_LVL, 0);
        chk("t6_rst_rdy_t", bus.TX_RDY_T, 0);
        chk("t6_rst_data", bus.TX_DATA_R, 0);
        chk("t6_rst_frm", bus.FRM_ERR_CT, 0);
        step(2);
        pc0 = pulse_ct;
        rst_n = 1'b1;
        bus.ECHO_EN = 1'b1;
        bus.TX_RDY_R = 1'b1;
        step(10);
        chk("t6_no_pulse_after_rst", pulse_ct, pc0);
        chk("t6_lvl_after_rst", bus.FIFO_LVL, 0);
        send(10'h05A);
        step(1);
        chk("t6_new_pulse", bus.TX_RDY_T, 1);
        chk("t6_new_data", bus.TX_DATA_R, 8'h5A);
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
